// File: rtl/axi_dma_pkg.sv
// Shared definitions for the read and write DMA engines: AXI encodings,
// burst geometry and the read-side state machine encoding.
package axi_dma_pkg;

   // AXI AxSIZE encodings (bytes per beat)
   localparam logic [2:0] SIZE_BYTE = 3'b000;
   localparam logic [2:0] SIZE_HALF = 3'b001;
   localparam logic [2:0] SIZE_WORD = 3'b010;

   // AXI xRESP encodings
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   // Longest burst issued, in beats, and its log2
   localparam int FIXED_BURST_SIZE = 256;
   localparam int LOG_BURST_SIZE   = 8;

   // Transaction ID used for every request
   localparam int DEFAULT_ID = 0;

   // Read DMA states
   typedef enum logic [1:0] {
      RD_IDLE,
      RD_PRE,
      RD_START,
      RD_SEQ
   } rd_state_e;

endpackage

// File: rtl/axi_dma_rd.sv
// AXI4 read DMA master: fetches num_trans 32-bit words starting at start_addr
// as incrementing bursts of up to 256 beats and passes them straight through
// to the user-side stream. Response and RLAST problems are flagged but never
// stop the transfer; burst termination is driven by the local beat counter.
module axi_dma_rd
   import axi_dma_pkg::*;
#(
   parameter int BITS_TRANS   = 18,
   parameter int AXI_WIDTH_ID = 4,
   parameter int AXI_WIDTH_AD = 32,
   parameter int AXI_WIDTH_DA = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   // AR channel
   output logic                    M_ARVALID,
   input  logic                    M_ARREADY,
   output logic [AXI_WIDTH_AD-1:0] M_ARADDR,
   output logic [7:0]              M_ARLEN,
   output logic [AXI_WIDTH_ID-1:0] M_ARID,
   output logic [2:0]              M_ARSIZE,
   output logic [1:0]              M_ARBURST,
   output logic [1:0]              M_ARLOCK,
   output logic [3:0]              M_ARCACHE,
   output logic [2:0]              M_ARPROT,
   output logic [3:0]              M_ARQOS,
   output logic [3:0]              M_ARREGION,
   output logic [3:0]              M_ARUSER,
   // R channel
   input  logic                    M_RVALID,
   output logic                    M_RREADY,
   input  logic [AXI_WIDTH_DA-1:0] M_RDATA,
   input  logic [1:0]              M_RRESP,
   input  logic                    M_RLAST,
   input  logic [AXI_WIDTH_ID-1:0] M_RID,
   // control and user side
   input  logic                    start_dma,
   input  logic [BITS_TRANS-1:0]   num_trans,
   input  logic [AXI_WIDTH_AD-1:0] start_addr,
   output logic                    done_o,
   output logic [AXI_WIDTH_DA-1:0] outdata,
   output logic                    outdata_vld,
   input  logic                    outdata_rdy,
   output logic                    fail_check,
   output logic                    err_sticky
);

   rd_state_e                 r_state;
   rd_state_e                 w_state_next;
   logic [BITS_TRANS-1:0]     r_num_trans;
   logic [BITS_TRANS-1:0]     r_burst_cnt;
   logic [AXI_WIDTH_AD-1:0]   r_addr;
   logic [7:0]                r_len;
   logic [7:0]                r_beat_cnt;
   logic                      r_fail;
   logic                      r_err;

   logic [BITS_TRANS-1:0]     w_remain;
   logic [7:0]                w_len_calc;
   logic [LOG_BURST_SIZE:0]   w_beats;
   logic                      w_all_done;
   logic                      w_beat;
   logic                      w_last_beat;
   logic                      w_err_beat;
   logic                      w_unused_rid;

   // Fixed AR attributes: single ID, 32-bit incrementing bursts, top QoS
   assign M_ARID     = AXI_WIDTH_ID'(DEFAULT_ID);
   assign M_ARSIZE   = SIZE_WORD;
   assign M_ARBURST  = 2'b01;
   assign M_ARLOCK   = 2'b00;
   assign M_ARCACHE  = 4'b0000;
   assign M_ARPROT   = 3'b000;
   assign M_ARQOS    = 4'b1111;
   assign M_ARREGION = 4'b0000;
   assign M_ARUSER   = 4'b0000;
   assign M_ARADDR   = r_addr;
   assign M_ARLEN    = r_len;
   assign fail_check = r_fail;
   assign err_sticky = r_err;

   // Response ID is not checked: only one ID is ever issued
   assign w_unused_rid = ^M_RID;

   // Burst sizing from the true remaining word count
   assign w_remain    = r_num_trans - r_burst_cnt;
   assign w_len_calc  = (w_remain >= BITS_TRANS'(FIXED_BURST_SIZE))
                        ? 8'(FIXED_BURST_SIZE - 1) : (w_remain[7:0] - 8'd1);
   assign w_beats     = {1'b0, r_len} + 9'd1;
   assign w_all_done  = (r_burst_cnt == r_num_trans);
   assign w_beat      = (r_state == RD_SEQ) && M_RVALID && outdata_rdy;
   assign w_last_beat = (r_beat_cnt == r_len);
   assign w_err_beat  = w_beat && ((M_RRESP != RESP_OKAY) || (M_RLAST != w_last_beat));

   // State register
   always_ff @(posedge clk) begin
      if (rst) r_state <= RD_IDLE;
      else     r_state <= w_state_next;
   end

   // Next-state decode and handshake outputs; R channel is a direct passthrough in RD_SEQ
   always_comb begin
      w_state_next = r_state;
      M_ARVALID    = 1'b0;
      M_RREADY     = 1'b0;
      outdata_vld  = 1'b0;
      outdata      = '0;
      done_o       = 1'b0;
      case (r_state)
         RD_IDLE: begin
            if (start_dma) w_state_next = RD_PRE;
         end
         RD_PRE: begin
            if (w_all_done) begin
               done_o       = 1'b1;
               w_state_next = RD_IDLE;
            end else begin
               w_state_next = RD_START;
            end
         end
         RD_START: begin
            M_ARVALID = 1'b1;
            if (M_ARREADY) w_state_next = RD_SEQ;
         end
         RD_SEQ: begin
            M_RREADY    = outdata_rdy;
            outdata_vld = M_RVALID;
            outdata     = M_RDATA;
            if (w_beat && w_last_beat) w_state_next = RD_PRE;
         end
         default: w_state_next = RD_IDLE;
      endcase
   end

   // Transfer bookkeeping: counters, address, burst length and error flags
   always_ff @(posedge clk) begin
      if (rst) begin
         r_num_trans <= '0;
         r_burst_cnt <= '0;
         r_addr      <= '0;
         r_len       <= '0;
         r_beat_cnt  <= '0;
         r_fail      <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_fail <= w_err_beat;
         if (w_err_beat) r_err <= 1'b1;
         case (r_state)
            RD_IDLE: begin
               if (start_dma) begin
                  r_num_trans <= num_trans;
                  r_addr      <= start_addr;
                  r_err       <= 1'b0;
               end
            end
            RD_PRE: begin
               if (w_all_done) r_burst_cnt <= '0;
               else            r_len       <= w_len_calc;
            end
            RD_SEQ: begin
               if (w_beat) begin
                  if (w_last_beat) begin
                     r_beat_cnt  <= '0;
                     r_burst_cnt <= r_burst_cnt + BITS_TRANS'(w_beats);
                     r_addr      <= r_addr + AXI_WIDTH_AD'({w_beats, 2'b00});
                  end else begin
                     r_beat_cnt  <= r_beat_cnt + 8'd1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_axi_dma_rd.sv
// Bench for axi_dma_rd: a reactive AXI read slave with a word-addressed
// memory model, a table of directed transfers and hand-written sequences for
// back-pressure, error responses, early RLAST, busy start and mid-burst reset.
module tb_axi_dma_rd;

   localparam int BT = 18;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        M_ARVALID, M_ARREADY;
   logic [31:0] M_ARADDR;
   logic [7:0]  M_ARLEN;
   logic [3:0]  M_ARID;
   logic [2:0]  M_ARSIZE;
   logic [1:0]  M_ARBURST, M_ARLOCK;
   logic [3:0]  M_ARCACHE;
   logic [2:0]  M_ARPROT;
   logic [3:0]  M_ARQOS, M_ARREGION, M_ARUSER;
   logic        M_RVALID, M_RREADY;
   logic [31:0] M_RDATA;
   logic [1:0]  M_RRESP;
   logic        M_RLAST;
   logic [3:0]  M_RID;
   logic        start_dma;
   logic [BT-1:0] num_trans;
   logic [31:0] start_addr;
   logic        done_o;
   logic [31:0] outdata;
   logic        outdata_vld, outdata_rdy;
   logic        fail_check, err_sticky;

   always #5 clk = ~clk;

   axi_dma_rd dut (
      .clk(clk), .rst(rst),
      .M_ARVALID(M_ARVALID), .M_ARREADY(M_ARREADY), .M_ARADDR(M_ARADDR), .M_ARLEN(M_ARLEN),
      .M_ARID(M_ARID), .M_ARSIZE(M_ARSIZE), .M_ARBURST(M_ARBURST), .M_ARLOCK(M_ARLOCK),
      .M_ARCACHE(M_ARCACHE), .M_ARPROT(M_ARPROT), .M_ARQOS(M_ARQOS), .M_ARREGION(M_ARREGION),
      .M_ARUSER(M_ARUSER),
      .M_RVALID(M_RVALID), .M_RREADY(M_RREADY), .M_RDATA(M_RDATA), .M_RRESP(M_RRESP),
      .M_RLAST(M_RLAST), .M_RID(M_RID),
      .start_dma(start_dma), .num_trans(num_trans), .start_addr(start_addr),
      .done_o(done_o), .outdata(outdata), .outdata_vld(outdata_vld), .outdata_rdy(outdata_rdy),
      .fail_check(fail_check), .err_sticky(err_sticky)
   );

   int n_chk  = 0;
   int n_pass = 0;
   int cyc    = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // slave and scoreboard state
   logic [31:0] ar_addr_q[$];
   int          ar_len_q[$];
   int          cur_beat = 0, gbeat = 0, rx_idx = 0, issued = 0;
   int          ar_cnt = 0, ar_err = 0, data_err = 0, mirror_err = 0;
   int          done_cnt = 0, fail_cnt = 0, last_len = 0;
   logic [31:0] last_addr = 0;
   int          start_cyc = 0, done_cyc = -1, first_ar_cyc = -1, last_beat_cyc = -1;
   int          xfer_num = 0;
   logic [31:0] xfer_base = 0;
   bit          rand_mode = 0;
   bit          rv_hold = 0;
   int          err_beat = -1;
   int          early_last = -1;

   typedef struct {
      int          num;
      logic [31:0] addr;
      int          exp_ars;
      int          exp_last_len;
      logic [31:0] exp_last_addr;
   } vec_t;

   vec_t vecs[7];

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[17:2], ~a[9:2], a[31:24]} ^ 32'h3C5A_96E1;
   endfunction

   task automatic chk(input string name, input longint act, input longint exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // Slave: drive on the falling edge, then observe the handshakes the next rising edge will complete
   always @(negedge clk) begin
      if (rand_mode) begin
         outdata_rdy = ($urandom_range(0, 2) != 0);
         M_ARREADY   = ($urandom_range(0, 1) == 1);
      end else begin
         outdata_rdy = 1'b1;
         M_ARREADY   = 1'b1;
      end
      if (ar_addr_q.size() > 0) begin
         if (!rv_hold) M_RVALID = rand_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
         M_RDATA = mem_word(ar_addr_q[0] + 32'(cur_beat * 4));
         M_RLAST = (cur_beat == ar_len_q[0]) || (cur_beat == early_last);
         M_RRESP = (gbeat == err_beat) ? 2'b10 : 2'b00;
      end else begin
         M_RVALID = 1'b0;
         M_RDATA  = 32'h0;
         M_RLAST  = 1'b0;
         M_RRESP  = 2'b00;
      end
      #1;
      if (rst) begin
         ar_addr_q.delete();
         ar_len_q.delete();
         cur_beat = 0;
         rv_hold  = 0;
         M_RVALID = 1'b0;
      end else begin
         if (M_RREADY !== ((ar_addr_q.size() > 0) && outdata_rdy)) mirror_err++;
         if (outdata_vld !== ((ar_addr_q.size() > 0) && M_RVALID)) mirror_err++;
         if (M_RVALID && M_RREADY) begin
            if (outdata !== mem_word(xfer_base + 32'(rx_idx * 4))) data_err++;
            rx_idx++;
            gbeat++;
            cur_beat++;
            last_beat_cyc = cyc;
            rv_hold = 0;
            if (cur_beat > ar_len_q[0]) begin
               void'(ar_addr_q.pop_front());
               void'(ar_len_q.pop_front());
               cur_beat = 0;
            end
         end else begin
            rv_hold = M_RVALID;
         end
         if (M_ARVALID && first_ar_cyc < 0) first_ar_cyc = cyc;
         if (M_ARVALID && M_ARREADY) begin
            int rem;
            int exp_len;
            rem     = xfer_num - issued;
            exp_len = (rem >= 256) ? 255 : rem - 1;
            if (rem <= 0 || M_ARADDR !== xfer_base + 32'(issued * 4) || M_ARLEN !== 8'(exp_len))
               ar_err++;
            if (M_ARSIZE !== 3'b010 || M_ARBURST !== 2'b01 || M_ARQOS !== 4'hF || M_ARID !== 4'h0 ||
                M_ARLOCK !== 2'b00 || M_ARCACHE !== 4'h0 || M_ARPROT !== 3'b000 ||
                M_ARREGION !== 4'h0 || M_ARUSER !== 4'h0)
               ar_err++;
            $display("AR addr=0x%08h len=%0d", M_ARADDR, M_ARLEN);
            ar_addr_q.push_back(M_ARADDR);
            ar_len_q.push_back(int'(M_ARLEN));
            issued    += int'(M_ARLEN) + 1;
            ar_cnt++;
            last_len  = int'(M_ARLEN);
            last_addr = M_ARADDR;
         end
         if (done_o) begin
            done_cnt++;
            done_cyc = cyc;
         end
         if (fail_check) fail_cnt++;
      end
   end

   task automatic begin_xfer(input int num, input logic [31:0] addr);
      @(negedge clk);
      xfer_num = num;  xfer_base = addr;
      issued = 0;  rx_idx = 0;  gbeat = 0;  cur_beat = 0;  rv_hold = 0;
      ar_cnt = 0;  ar_err = 0;  data_err = 0;  mirror_err = 0;
      done_cnt = 0;  fail_cnt = 0;  last_len = 0;  last_addr = 0;
      first_ar_cyc = -1;  done_cyc = -1;  last_beat_cyc = -1;
      ar_addr_q.delete();
      ar_len_q.delete();
      start_dma  = 1'b1;
      num_trans  = BT'(num);
      start_addr = addr;
      start_cyc  = cyc;
      @(negedge clk);
      start_dma = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      for (int c = 0; c < budget; c++) begin
         @(negedge clk);
         #2;
         if (done_cnt != 0) break;
      end
      repeat (3) @(negedge clk);
      #2;
   endtask

   task automatic wait_words(input int n, input int budget);
      for (int c = 0; c < budget; c++) begin
         @(negedge clk);
         #2;
         if (rx_idx >= n) break;
      end
      chk("reached_words", (rx_idx >= n) ? 1 : 0, 1);
   endtask

   task automatic check_xfer(input string name, input int exp_ars, input int exp_last_len,
                             input logic [31:0] exp_last_addr, input int exp_fail, input int num);
      $display("xfer %s: num=%0d ars=%0d words=%0d dones=%0d fails=%0d", name, num, ar_cnt, rx_idx, done_cnt, fail_cnt);
      chk({name, ".done_cnt"},   done_cnt,   1);
      chk({name, ".ar_cnt"},     ar_cnt,     exp_ars);
      chk({name, ".last_len"},   last_len,   exp_last_len);
      chk({name, ".last_addr"},  last_addr,  exp_last_addr);
      chk({name, ".words"},      rx_idx,     num);
      chk({name, ".data_err"},   data_err,   0);
      chk({name, ".ar_err"},     ar_err,     0);
      chk({name, ".mirror_err"}, mirror_err, 0);
      chk({name, ".fail_cnt"},   fail_cnt,   exp_fail);
   endtask

   task automatic check_idle_outputs(input string name);
      chk({name, ".arvalid"},    M_ARVALID,   0);
      chk({name, ".rready"},     M_RREADY,    0);
      chk({name, ".outdata_vld"}, outdata_vld, 0);
      chk({name, ".outdata"},    outdata,     0);
      chk({name, ".done"},       done_o,      0);
      chk({name, ".fail_check"}, fail_check,  0);
      chk({name, ".err_sticky"}, err_sticky,  0);
      chk({name, ".araddr"},     M_ARADDR,    0);
      chk({name, ".arlen"},      M_ARLEN,     0);
   endtask

   initial begin
      //          num   addr           ars  last_len  last_addr
      vecs[0] = '{600, 32'h1000_0000, 3,   87,       32'h1000_0800};
      vecs[1] = '{256, 32'h2000_0400, 1,   255,      32'h2000_0400};
      vecs[2] = '{0,   32'h2100_0000, 0,   0,        32'h0000_0000};
      vecs[3] = '{1,   32'h0000_0000, 1,   0,        32'h0000_0000};
      vecs[4] = '{257, 32'h3000_0000, 2,   0,        32'h3000_0400};
      vecs[5] = '{512, 32'h3100_0000, 2,   255,      32'h3100_0400};
      vecs[6] = '{4,   32'hFFFF_FC00, 1,   3,        32'hFFFF_FC00};

      start_dma   = 1'b0;
      num_trans   = '0;
      start_addr  = 32'h0;
      M_ARREADY   = 1'b0;
      M_RVALID    = 1'b0;
      M_RDATA     = 32'h0;
      M_RRESP     = 2'b00;
      M_RLAST     = 1'b0;
      M_RID       = 4'h0;
      outdata_rdy = 1'b0;
      rst         = 1'b1;

      repeat (3) @(negedge clk);
      #2;
      check_idle_outputs("reset");
      @(negedge clk);
      rst = 1'b0;

      // directed transfers with an always-ready slave
      for (int i = 0; i < 7; i++) begin
         begin_xfer(vecs[i].num, vecs[i].addr);
         wait_done(2000);
         check_xfer($sformatf("vec%0d", i), vecs[i].exp_ars, vecs[i].exp_last_len,
                    vecs[i].exp_last_addr, 0, vecs[i].num);
         // done is visible in the cycle after the one that samples start (num=0),
         // or in the cycle right after the final beat is taken
         if (vecs[i].num == 0) chk($sformatf("vec%0d.done_lat", i), done_cyc - start_cyc, 1);
         else                  chk($sformatf("vec%0d.done_after_last", i), done_cyc - last_beat_cyc, 1);
         // ARVALID appears two cycles after start is sampled (one RD_PRE cycle in between)
         if (vecs[i].exp_ars != 0) chk($sformatf("vec%0d.arvalid_lat", i), first_ar_cyc - start_cyc, 2);
      end

      // random RVALID gaps, ARREADY stalls and user back-pressure
      rand_mode = 1;
      begin_xfer(300, 32'h4000_0000);
      wait_done(5000);
      rand_mode = 0;
      check_xfer("gaps", 2, 43, 32'h4000_0400, 0, 300);

      // SLVERR on beat 10 of 40: one pulse, sticky until the next start
      err_beat = 10;
      begin_xfer(40, 32'h5000_0000);
      wait_done(2000);
      err_beat = -1;
      check_xfer("slverr", 1, 39, 32'h5000_0000, 1, 40);
      chk("slverr.sticky", err_sticky, 1);
      repeat (5) @(negedge clk);
      #2;
      chk("slverr.sticky_hold", err_sticky, 1);
      begin_xfer(8, 32'h5000_1000);
      #2;
      chk("slverr.sticky_clear", err_sticky, 0);
      wait_done(2000);
      check_xfer("after_err", 1, 7, 32'h5000_1000, 0, 8);

      // RLAST early on beat 5 of a 16-beat burst: flagged, all 16 beats still consumed
      early_last = 5;
      begin_xfer(16, 32'h6000_0000);
      wait_done(2000);
      early_last = -1;
      check_xfer("early_last", 1, 15, 32'h6000_0000, 1, 16);

      // start_dma while busy is ignored
      begin_xfer(300, 32'h7000_0000);
      wait_words(50, 2000);
      @(negedge clk);
      start_dma  = 1'b1;
      num_trans  = BT'(4);
      start_addr = 32'h7100_0000;
      @(negedge clk);
      start_dma = 1'b0;
      wait_done(3000);
      check_xfer("busy_start", 2, 43, 32'h7000_0400, 0, 300);

      // reset mid-burst, then a fresh short transfer
      begin_xfer(600, 32'h1800_0000);
      wait_words(20, 2000);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      #2;
      check_idle_outputs("mid_rst");
      @(negedge clk);
      rst = 1'b0;
      begin_xfer(4, 32'h1900_0000);
      wait_done(500);
      check_xfer("post_rst", 1, 3, 32'h1900_0000, 0, 4);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
